// File: rtl/inst_fetch.sv
// Instruction-fetch initiator for a combinational instruction ROM.
// Owns the PC, issues one ROM read per cycle while the fetch FIFO has room,
// buffers {pc, inst} pairs and hands them to decode over valid/ready.
// A redirect reloads the PC and flushes every buffered pair.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rom_ce          ROM chip enable (fetch this cycle)
//   rom_addr        ROM byte address, always the current PC
//   rom_inst        ROM read data, same cycle as rom_ce/rom_addr
//   redirect_i      load redirect_pc_i (word aligned) and flush the FIFO
//   redirect_pc_i   redirect target, bits [1:0] ignored
//   if_valid        FIFO head holds a valid pair
//   if_ready        decode accepts the head this cycle
//   if_pc, if_inst  head pair, zero when the FIFO is empty
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // The ROM ignores the low address bits, so the redirect target is simply masked.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full check uses the registered count only; a same-cycle pop does not free a slot.
  assign rom_ce   = !rst && !redirect_i && (count < CNT_W'(DEPTH));
  assign rom_addr = pc;
  assign push     = rom_ce;
  assign pop      = if_valid && if_ready;

  // Head is read from registered storage, so rom_inst never reaches if_* directly.
  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign if_inst  = if_valid ? inst_mem[rd_ptr] : 32'h0;

  // PC and FIFO control; reset beats redirect, redirect beats push/pop/stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_i) begin
      pc     <= {redirect_pc_i[31:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= rom_inst;
    end
  end

endmodule
